// File: rtl/register64_reader.sv
// rtl/register64_reader.sv - captures a parallel word and streams it out one byte at a time
// Optional build macro READER_MSB_FIRST_EN: send the most significant byte first.
module register64_reader #(
    parameter int NUM_BYTES = 8,
    parameter int BYTE_W    = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [NUM_BYTES*BYTE_W-1:0] reg_data,
    output logic [BYTE_W-1:0]           byte_out,
    output logic                        byte_valid,
    input  logic                        byte_ready,
    output logic                        byte_last,
    output logic                        busy,
    output logic                        done
);
    localparam int WORD_W = NUM_BYTES * BYTE_W;
    localparam int CNT_W  = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_BYTES - 1);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        DONE
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [WORD_W-1:0]      shadow;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       byte_idx;
    logic [BYTE_W-1:0]      shadow_bytes [NUM_BYTES];

    for (genvar i = 0; i < NUM_BYTES; i++) begin : g_bytes
        assign shadow_bytes[i] = shadow[i*BYTE_W +: BYTE_W];
    end

`ifdef READER_MSB_FIRST_EN
    assign byte_idx = LAST_CNT - cnt;
`else
    assign byte_idx = cnt;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            shadow <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && start) begin
                shadow <= reg_data;
                cnt    <= '0;
            end else if (state == SEND && byte_ready) begin
                // the counter wraps on the final transfer so it is already 0 in DONE
                cnt <= (cnt == LAST_CNT) ? '0 : cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        byte_out   = '0;
        byte_valid = 1'b0;
        byte_last  = 1'b0;
        done       = 1'b0;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                if (start) state_nxt = SEND;
            end
            SEND: begin
                byte_valid = 1'b1;
                byte_out   = shadow_bytes[byte_idx];
                byte_last  = (cnt == LAST_CNT);
                if (byte_ready && cnt == LAST_CNT) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule
